aer_phase_receiver: RTL

- Clocked consumer directly downstream of the asynchronous Fs control-signal generator in the Address Event Controller.
- Synchronises the generator's 2-bit phase code (bit1, bit0) and the bundled AER address into the clock domain.
- Treats every legal Gray-code step as one request: captures the address into an event FIFO and toggles ack back to the generator (two-phase handshake).
- Applies back-pressure by withholding ack while the FIFO is full, and flags protocol violations.

---
 rtl/aer_phase_receiver.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/aer_phase_receiver.sv
// Clocked receiver for the AER phase-code generator: synchronises the
// four-phase Gray code, queues each accepted step and toggles ack back.
module aer_phase_receiver #(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bit0,
    input  logic          bit1,
    input  logic [AW-1:0] addr_in,
    output logic          ack,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [AW-1:0] ev_addr,
    output logic [1:0]    ev_phase,
    output logic [LW-1:0] fifo_level,
    output logic [CW-1:0] event_count,
    output logic          err,
    input  logic          err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] CODE_RST = 2'b01;

    state_t            state_q, state_d;
    logic [1:0]        code_s1_q, code_s1_d;
    logic [1:0]        code_s2_q, code_s2_d;
    logic [AW-1:0]     addr_s1_q, addr_s1_d;
    logic [AW-1:0]     addr_s2_q, addr_s2_d;
    logic [1:0]        last_code_q, last_code_d;
    logic [1:0]        new_code_q, new_code_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [AW+1:0]     mem_q [DEPTH];
    logic [AW+1:0]     mem_d [DEPTH];
    logic              push;
    logic              pop;
    logic              full;

    function automatic logic [1:0] succ(input logic [1:0] c);
        logic [1:0] r;
        case (c)
            2'b01:   r = 2'b11;
            2'b11:   r = 2'b10;
            2'b10:   r = 2'b00;
            default: r = 2'b01;
        endcase
        return r;
    endfunction

    // Full uses the registered level, so a same-cycle pop cannot free a slot.
    assign full     = (level_q == LW'(DEPTH));
    assign ev_valid = (level_q != '0);
    assign pop      = ev_valid && ev_ready;

    always_comb begin
        code_s1_d   = {bit1, bit0};
        code_s2_d   = code_s1_q;
        addr_s1_d   = addr_in;
        addr_s2_d   = addr_s1_q;
        state_d     = state_q;
        last_code_d = last_code_q;
        new_code_d  = new_code_q;
        ack_d       = ack_q;
        err_d       = err_q & ~err_clr;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        mem_d       = mem_q;
        push        = 1'b0;

        case (state_q)
            IDLE: begin
                if (code_s2_q != last_code_q) begin
                    if (code_s2_q == succ(last_code_q)) begin
                        new_code_d = code_s2_q;
                        state_d    = PUSH;
                    end else begin
                        err_d       = 1'b1;
                        last_code_d = code_s2_q;
                    end
                end
            end
            PUSH: begin
                if (!full) begin
                    push        = 1'b1;
                    last_code_d = new_code_q;
                    ack_d       = ~ack_q;
                    count_d     = count_q + 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = {new_code_q, addr_s2_q};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            code_s1_q   <= CODE_RST;
            code_s2_q   <= CODE_RST;
            addr_s1_q   <= '0;
            addr_s2_q   <= '0;
            last_code_q <= CODE_RST;
            new_code_q  <= CODE_RST;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            code_s1_q   <= code_s1_d;
            code_s2_q   <= code_s2_d;
            addr_s1_q   <= addr_s1_d;
            addr_s2_q   <= addr_s2_d;
            last_code_q <= last_code_d;
            new_code_q  <= new_code_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            mem_q       <= mem_d;
        end
    end

    assign ack         = ack_q;
    assign err         = err_q;
    assign event_count = count_q;
    assign fifo_level  = level_q;
    assign ev_addr     = ev_valid ? mem_q[rd_ptr_q][AW-1:0] : '0;
    assign ev_phase    = ev_valid ? mem_q[rd_ptr_q][AW+1:AW] : 2'b00;

endmodule
